// File: rtl/id_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, decode bundles
// and the immediate-extraction helpers used by id_decode_stage and imm_gen.
package id_decode_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_XOR    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_AND    = 4'h4,
        ALU_SLL    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SRA    = 4'h7,
        ALU_SLT    = 4'h8,
        ALU_SLTU   = 4'h9,
        ALU_PC_IMM = 4'hA,
        ALU_PASS_B = 4'hB,
        ALU_MUL    = 4'hC,
        ALU_MULH   = 4'hD,
        ALU_MULHSU = 4'hE,
        ALU_MULHU  = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic    legal;
        logic    use_rs1;
        logic    use_rs2;
        alu_op_e alu;
        logic    alu_src;
        logic    branch;
        logic    jump;
        logic    jalr;
        logic    auipc;
        logic    mem_ren;
        logic    mem_wen;
        logic    wb_sel;
        logic    reg_wb;
    } dec_t;

    typedef struct packed {
        alu_op_e    alu;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       auipc;
        logic       mem_ren;
        logic       mem_wen;
        logic       wb_sel;
        logic       reg_wb;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } idex_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID -> ID/EX bundle: instruction handshake in, decoded ID/EX register out.
// The decode stage uses the master modport; the surrounding pipeline uses slave.
interface id_decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int ILL_CNT_W  = 16
);
    logic [31:0]           instr_in;
    logic [XLEN-1:0]       pc_in;
    logic                  if_valid;
    logic                  id_ready;
    logic                  ex_ready;
    logic                  flush;
    logic                  ex_valid;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl;
    logic                  ex_alu_src;
    logic                  ex_branch;
    logic                  ex_jump;
    logic                  ex_jalr;
    logic                  ex_auipc;
    logic                  ex_mem_ren;
    logic                  ex_mem_wen;
    logic                  ex_wb_sel;
    logic                  ex_reg_wb;
    logic [2:0]            ex_funct3;
    logic [4:0]            ex_rd;
    logic [4:0]            ex_rs1;
    logic [4:0]            ex_rs2;
    logic [XLEN-1:0]       ex_imm;
    logic [XLEN-1:0]       ex_pc;
    logic [ILL_CNT_W-1:0]  ill_count;

    modport master (
        input  instr_in, pc_in, if_valid, ex_ready, flush,
        output id_ready, ex_valid, ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump,
               ex_jalr, ex_auipc, ex_mem_ren, ex_mem_wen, ex_wb_sel, ex_reg_wb,
               ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc, ill_count
    );

    modport slave (
        output instr_in, pc_in, if_valid, ex_ready, flush,
        input  id_ready, ex_valid, ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump,
               ex_jalr, ex_auipc, ex_mem_ren, ex_mem_wen, ex_wb_sel, ex_reg_wb,
               ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc, ill_count
    );
endinterface

// File: rtl/id_decode_stage_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J immediate by opcode
// and sign-extends it to XLEN. Opcodes without an immediate yield zero.
module imm_gen
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm32 = imm_i(instr);
            OPC_STORE:                      imm32 = imm_s(instr);
            OPC_BRANCH:                     imm32 = imm_b(instr);
            OPC_LUI, OPC_AUIPC:             imm32 = imm_u(instr);
            OPC_JAL:                        imm32 = imm_j(instr);
            default:                        imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage: decode, load-use bubble insertion, flush and
// ID/EX register with saturating illegal count. Define RV_MEXT_EN for MUL*.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int ILL_CNT_W  = 16
) (
    input logic               clk,
    input logic               reset,
    id_decode_stage_if.master bus
);
    logic [31:0]          instr;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [XLEN-1:0]      imm;
    dec_t                 dec;
    idex_t                idex_d, ex_q;
    logic                 valid_q;
    logic [XLEN-1:0]      imm_q, pc_q;
    logic [ILL_CNT_W-1:0] ill_q;
    logic                 hazard;

    assign instr = bus.instr_in;
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr(instr), .imm(imm));

    always_comb begin
        dec = '0;
        case (instr[6:0])
            OPC_LUI: begin
                dec = '{legal: 1'b1, alu: ALU_PASS_B, alu_src: 1'b1, reg_wb: 1'b1, default: '0};
            end
            OPC_AUIPC: begin
                dec = '{legal: 1'b1, alu: ALU_PC_IMM, alu_src: 1'b1, auipc: 1'b1, reg_wb: 1'b1, default: '0};
            end
            OPC_JAL: begin
                dec = '{legal: 1'b1, alu: ALU_PC_IMM, alu_src: 1'b1, jump: 1'b1, reg_wb: 1'b1, default: '0};
            end
            OPC_JALR: begin
                dec = '{legal: (f3 == 3'b000), use_rs1: 1'b1, alu: ALU_PC_IMM, alu_src: 1'b1,
                        jump: 1'b1, jalr: 1'b1, reg_wb: 1'b1, default: '0};
            end
            OPC_BRANCH: begin
                dec = '{legal: (f3 != 3'b010) && (f3 != 3'b011), use_rs1: 1'b1, use_rs2: 1'b1,
                        alu: ALU_SUB, branch: 1'b1, default: '0};
            end
            OPC_LOAD: begin
                dec = '{legal: (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111), use_rs1: 1'b1,
                        alu: ALU_ADD, alu_src: 1'b1, mem_ren: 1'b1, wb_sel: 1'b1, reg_wb: 1'b1,
                        default: '0};
            end
            OPC_STORE: begin
                dec = '{legal: (f3 <= 3'b010), use_rs1: 1'b1, use_rs2: 1'b1, alu: ALU_ADD,
                        alu_src: 1'b1, mem_wen: 1'b1, default: '0};
            end
            OPC_OP_IMM: begin
                dec.use_rs1 = 1'b1;
                dec.alu_src = 1'b1;
                dec.reg_wb  = 1'b1;
                dec.alu     = alu_from_funct3(f3, instr[30] & (f3 == 3'b101));
                if (f3 == 3'b001)
                    dec.legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    dec.legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    dec.legal = 1'b1;
            end
            OPC_OP: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.reg_wb  = 1'b1;
                if (f7 == 7'b0000000) begin
                    dec.legal = 1'b1;
                    dec.alu   = alu_from_funct3(f3, 1'b0);
                end else if (f7 == 7'b0100000) begin
                    dec.legal = (f3 == 3'b000) || (f3 == 3'b101);
                    dec.alu   = alu_from_funct3(f3, 1'b1);
                end else if (f7 == 7'b0000001) begin
`ifdef RV_MEXT_EN
                    // MUL/MULH/MULHSU/MULHU only; DIV/REM stay illegal
                    dec.legal = ~f3[2];
                    dec.alu   = alu_op_e'({2'b11, f3[1:0]});
`else
                    dec.legal = 1'b0;
`endif
                end
            end
            default: dec = '0;
        endcase
    end

    always_comb begin
        idex_d         = '0;
        idex_d.alu     = dec.alu;
        idex_d.alu_src = dec.alu_src;
        idex_d.branch  = dec.branch;
        idex_d.jump    = dec.jump;
        idex_d.jalr    = dec.jalr;
        idex_d.auipc   = dec.auipc;
        idex_d.mem_ren = dec.mem_ren;
        idex_d.mem_wen = dec.mem_wen;
        idex_d.wb_sel  = dec.wb_sel;
        idex_d.reg_wb  = dec.reg_wb & (instr[11:7] != 5'd0);
        idex_d.funct3  = f3;
        idex_d.rd      = instr[11:7];
        idex_d.rs1     = instr[19:15];
        idex_d.rs2     = instr[24:20];
    end

    assign hazard = valid_q & ex_q.mem_ren & (ex_q.rd != 5'd0) &
                    ((dec.use_rs1 & (idex_d.rs1 == ex_q.rd)) |
                     (dec.use_rs2 & (idex_d.rs2 == ex_q.rd)));

    assign bus.id_ready = bus.flush | (bus.ex_ready & ~hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ill_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (bus.ex_ready) begin
            if (hazard) begin
                valid_q <= 1'b0;
            end else if (bus.if_valid && dec.legal) begin
                valid_q <= 1'b1;
                ex_q    <= idex_d;
                imm_q   <= imm;
                pc_q    <= bus.pc_in;
            end else begin
                valid_q <= 1'b0;
                if (bus.if_valid && !(&ill_q))
                    ill_q <= ill_q + 1'b1;
            end
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_alu_ctrl = ALU_CTRL_W'(ex_q.alu);
    assign bus.ex_alu_src  = ex_q.alu_src;
    assign bus.ex_branch   = ex_q.branch;
    assign bus.ex_jump     = ex_q.jump;
    assign bus.ex_jalr     = ex_q.jalr;
    assign bus.ex_auipc    = ex_q.auipc;
    assign bus.ex_mem_ren  = ex_q.mem_ren;
    assign bus.ex_mem_wen  = ex_q.mem_wen;
    assign bus.ex_wb_sel   = ex_q.wb_sel;
    assign bus.ex_reg_wb   = ex_q.reg_wb;
    assign bus.ex_funct3   = ex_q.funct3;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ill_count   = ill_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vector table plus hand sequences
// for load-use, flush, stall, reset, M-extension and counter saturation.
module tb_id_decode_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_decode_stage_if #(.XLEN(32), .ALU_CTRL_W(4), .ILL_CNT_W(16)) m_if ();
    id_decode_stage_if #(.XLEN(32), .ALU_CTRL_W(4), .ILL_CNT_W(2))  s_if ();

    id_decode_stage #(.XLEN(32), .ALU_CTRL_W(4), .ILL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(m_if));
    id_decode_stage #(.XLEN(32), .ALU_CTRL_W(4), .ILL_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(s_if));

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [12:0] ctrl;   // {alu[3:0], src, br, jmp, jalr, auipc, ren, wen, wbsel, regwb}
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int exp_ill = 0;
    vec_t tbl[28];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                         input logic rdy, input logic fl);
        m_if.instr_in = ins;
        m_if.pc_in    = pc;
        m_if.if_valid = v;
        m_if.ex_ready = rdy;
        m_if.flush    = fl;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic lg, input logic [3:0] alu,
                                input logic [8:0] fl, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] imm);
        vec_t v;
        v.instr = ins; v.legal = lg; v.ctrl = {alu, fl}; v.f3 = f3; v.rd = rd; v.imm = imm;
        return v;
    endfunction

    function automatic logic [12:0] get_ctrl();
        return {m_if.ex_alu_ctrl, m_if.ex_alu_src, m_if.ex_branch, m_if.ex_jump, m_if.ex_jalr,
                m_if.ex_auipc, m_if.ex_mem_ren, m_if.ex_mem_wen, m_if.ex_wb_sel, m_if.ex_reg_wb};
    endfunction

    initial begin
        logic [31:0] lw_x2;
        logic [1:0]  sat_exp[4];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
        lw_x2   = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011);

        tbl[0]  = mk(32'h00500093, 1, 4'h0, 9'b100000001, 3'd0, 5'd1, 32'h5);
        tbl[1]  = mk(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 1, 4'h1, 9'b000000001, 3'd0, 5'd3, 32'h0);
        tbl[2]  = mk(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd4, 7'b0010011), 1, 4'h7, 9'b100000001, 3'd5, 5'd4, 32'h403);
        tbl[3]  = mk(enc_i({7'b0000000, 5'd3}, 5'd1, 3'b101, 5'd4, 7'b0010011), 1, 4'h6, 9'b100000001, 3'd5, 5'd4, 32'h3);
        tbl[4]  = mk(enc_i(12'hFFF, 5'd1, 3'b100, 5'd5, 7'b0010011), 1, 4'h2, 9'b100000001, 3'd4, 5'd5, 32'hFFFFFFFF);
        tbl[5]  = mk(enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd6), 1, 4'h9, 9'b000000001, 3'd3, 5'd6, 32'h0);
        tbl[6]  = mk(enc_r(7'b0, 5'd2, 5'd1, 3'b010, 5'd6), 1, 4'h8, 9'b000000001, 3'd2, 5'd6, 32'h0);
        tbl[7]  = mk(enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd6), 1, 4'h3, 9'b000000001, 3'd6, 5'd6, 32'h0);
        tbl[8]  = mk(enc_r(7'b0, 5'd2, 5'd1, 3'b111, 5'd6), 1, 4'h4, 9'b000000001, 3'd7, 5'd6, 32'h0);
        tbl[9]  = mk(enc_r(7'b0, 5'd2, 5'd1, 3'b001, 5'd6), 1, 4'h5, 9'b000000001, 3'd1, 5'd6, 32'h0);
        tbl[10] = mk(enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd6), 1, 4'h7, 9'b000000001, 3'd5, 5'd6, 32'h0);
        tbl[11] = mk(enc_r(7'b0, 5'd2, 5'd1, 3'b101, 5'd6), 1, 4'h6, 9'b000000001, 3'd5, 5'd6, 32'h0);
        tbl[12] = mk(enc_i(12'hFFC, 5'd1, 3'b010, 5'd7, 7'b0000011), 1, 4'h0, 9'b100001011, 3'd2, 5'd7, 32'hFFFFFFFC);
        tbl[13] = mk(enc_s(12'd8, 5'd2, 5'd1, 3'b010), 1, 4'h0, 9'b100000100, 3'd2, 5'd8, 32'h8);
        tbl[14] = mk(enc_b(13'h1FF0, 5'd2, 5'd1, 3'b001), 1, 4'h1, 9'b010000000, 3'd1, 5'd17, 32'hFFFFFFF0);
        tbl[15] = mk(enc_u(20'h12345, 5'd8, 7'b0110111), 1, 4'hB, 9'b100000001, 3'd5, 5'd8, 32'h12345000);
        tbl[16] = mk(enc_u(20'hFFFFF, 5'd9, 7'b0010111), 1, 4'hA, 9'b100010001, 3'd7, 5'd9, 32'hFFFFF000);
        tbl[17] = mk(enc_j(21'd2048, 5'd1), 1, 4'hA, 9'b101000001, 3'd0, 5'd1, 32'h800);
        tbl[18] = mk(enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111), 1, 4'hA, 9'b101100000, 3'd0, 5'd0, 32'h0);
        tbl[19] = mk(32'h00000013, 1, 4'h0, 9'b100000000, 3'd0, 5'd0, 32'h0);
        tbl[20] = mk(enc_i({7'b0100000, 5'd1}, 5'd1, 3'b001, 5'd2, 7'b0010011), 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[21] = mk(enc_r(7'b0100000, 5'd2, 5'd1, 3'b100, 5'd3), 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[22] = mk(enc_b(13'd8, 5'd2, 5'd1, 3'b010), 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[23] = mk(enc_i(12'd0, 5'd1, 3'b011, 5'd2, 7'b0000011), 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[24] = mk(enc_s(12'd0, 5'd2, 5'd1, 3'b011), 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[25] = mk(enc_i(12'd0, 5'd1, 3'b001, 5'd2, 7'b1100111), 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[26] = mk(32'h0000000F, 0, 4'h0, 9'b0, 3'd0, 5'd0, 32'h0);
        tbl[27] = mk(enc_r(7'b0, 5'd12, 5'd11, 3'b000, 5'd10), 1, 4'h0, 9'b000000001, 3'd0, 5'd10, 32'h0);

        s_if.instr_in = 32'hFFFFFFFF; s_if.pc_in = '0; s_if.if_valid = 1'b0;
        s_if.ex_ready = 1'b1; s_if.flush = 1'b0;

        // reset dominates a valid instruction being offered
        reset = 1'b1;
        drive(32'h00500093, 32'h44, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_valid", m_if.ex_valid, 0);
        chk("rst_ill", m_if.ill_count, 0);
        chk("rst_ctrl", get_ctrl(), 0);
        chk("rst_imm", m_if.ex_imm, 0);
        chk("rst_pc", m_if.ex_pc, 0);
        chk("rst_rd", m_if.ex_rd, 0);
        chk("rst_sat_ill", s_if.ill_count, 0);
        reset = 1'b0;

        for (int k = 0; k < 28; k++) begin
            drive(tbl[k].instr, 32'h1000 + 32'(k * 4), 1'b1, 1'b1, 1'b0);
            #1 chk($sformatf("v%0d_id_ready", k), m_if.id_ready, 1);
            tick();
            if (!tbl[k].legal) exp_ill++;
            chk($sformatf("v%0d_valid", k), m_if.ex_valid, tbl[k].legal);
            chk($sformatf("v%0d_ill", k), m_if.ill_count, exp_ill);
            if (tbl[k].legal) begin
                chk($sformatf("v%0d_ctrl", k), get_ctrl(), tbl[k].ctrl);
                chk($sformatf("v%0d_f3", k), m_if.ex_funct3, tbl[k].f3);
                chk($sformatf("v%0d_rd", k), m_if.ex_rd, tbl[k].rd);
                chk($sformatf("v%0d_imm", k), m_if.ex_imm, tbl[k].imm);
                chk($sformatf("v%0d_pc", k), m_if.ex_pc, 32'h1000 + 32'(k * 4));
            end
        end

        // stall: ex_ready low for 3 cycles, outputs frozen, nothing counted
        drive(32'h00500093, 32'h2000, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3) :
                  (k == 1) ? 32'hFFFFFFFF : lw_x2, 32'h2004 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
            #1 chk($sformatf("hold%0d_id_ready", k), m_if.id_ready, 0);
            tick();
            chk($sformatf("hold%0d_valid", k), m_if.ex_valid, 1);
            chk($sformatf("hold%0d_ctrl", k), get_ctrl(), 13'b0000_100000001);
            chk($sformatf("hold%0d_imm_rd_pc", k), {m_if.ex_imm, m_if.ex_rd, m_if.ex_pc}, {32'h5, 5'd1, 32'h2000});
            chk($sformatf("hold%0d_ill", k), m_if.ill_count, exp_ill);
        end

        // load-use on rs1: exactly one bubble
        drive(lw_x2, 32'h3000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("lu_load_ren", {m_if.ex_valid, m_if.ex_mem_ren, m_if.ex_rd}, {1'b1, 1'b1, 5'd2});
        drive(enc_r(7'b0, 5'd1, 5'd2, 3'b000, 5'd3), 32'h3004, 1'b1, 1'b1, 1'b0);
        #1 chk("lu_id_ready_stall", m_if.id_ready, 0);
        tick();
        chk("lu_bubble", m_if.ex_valid, 0);
        #1 chk("lu_id_ready_after", m_if.id_ready, 1);
        tick();
        chk("lu_accept", {m_if.ex_valid, m_if.ex_rd, m_if.ex_rs1, m_if.ex_rs2, m_if.ex_pc},
            {1'b1, 5'd3, 5'd2, 5'd1, 32'h3004});

        // I-type does not use rs2 even when the immediate bits match the load rd
        drive(lw_x2, 32'h3010, 1'b1, 1'b1, 1'b0);
        tick();
        drive(enc_i(12'd2, 5'd1, 3'b000, 5'd3, 7'b0010011), 32'h3014, 1'b1, 1'b1, 1'b0);
        #1 chk("lu_itype_rs2_ready", m_if.id_ready, 1);
        tick();
        chk("lu_itype_valid", {m_if.ex_valid, m_if.ex_rd}, {1'b1, 5'd3});

        // store data register (rs2) does create a hazard
        drive(lw_x2, 32'h3020, 1'b1, 1'b1, 1'b0);
        tick();
        drive(enc_s(12'd0, 5'd2, 5'd5, 3'b010), 32'h3024, 1'b1, 1'b1, 1'b0);
        #1 chk("lu_store_rs2_stall", m_if.id_ready, 0);
        tick();
        chk("lu_store_bubble", m_if.ex_valid, 0);
        tick();
        chk("lu_store_accept", {m_if.ex_valid, m_if.ex_mem_wen}, {1'b1, 1'b1});

        // LUI has no rs1 even though instr[19:15] matches
        drive(lw_x2, 32'h3030, 1'b1, 1'b1, 1'b0);
        tick();
        drive(enc_u(20'h00010, 5'd4, 7'b0110111), 32'h3034, 1'b1, 1'b1, 1'b0);
        #1 chk("lu_lui_ready", m_if.id_ready, 1);
        tick();

        // load into x0 never stalls
        drive(enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011), 32'h3040, 1'b1, 1'b1, 1'b0);
        tick();
        drive(enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd3), 32'h3044, 1'b1, 1'b1, 1'b0);
        #1 chk("lu_x0_ready", m_if.id_ready, 1);
        tick();
        chk("lu_x0_valid", m_if.ex_valid, 1);

        // flush kills the presented instruction and does not count illegal ones
        drive(enc_b(13'd8, 5'd2, 5'd1, 3'b000), 32'h5000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("fl_beq", {m_if.ex_valid, m_if.ex_branch, m_if.ex_imm}, {1'b1, 1'b1, 32'h8});
        drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h5004, 1'b1, 1'b1, 1'b1);
        #1 chk("fl_id_ready", m_if.id_ready, 1);
        tick();
        chk("fl_valid", m_if.ex_valid, 0);
        chk("fl_ill", m_if.ill_count, exp_ill);
        drive(32'hFFFFFFFF, 32'h5008, 1'b1, 1'b1, 1'b1);
        tick();
        chk("fl_illegal_not_counted", m_if.ill_count, exp_ill);
        drive(lw_x2, 32'h500C, 1'b1, 1'b1, 1'b0);
        tick();
        drive(enc_r(7'b0, 5'd1, 5'd2, 3'b000, 5'd3), 32'h5010, 1'b1, 1'b0, 1'b1);
        #1 chk("fl_overrides_hazard_ready", m_if.id_ready, 1);
        tick();
        chk("fl_hazard_valid", m_if.ex_valid, 0);

        // M extension
        drive(32'h027302B3, 32'h6000, 1'b1, 1'b1, 1'b0);
        tick();
`ifdef RV_MEXT_EN
        chk("mul_decode", {m_if.ex_valid, m_if.ex_alu_ctrl, m_if.ex_rd, m_if.ex_reg_wb}, {1'b1, 4'hC, 5'd5, 1'b1});
`else
        exp_ill++;
        chk("mul_illegal", m_if.ex_valid, 0);
`endif
        chk("mul_ill", m_if.ill_count, exp_ill);
        drive(enc_r(7'b0000001, 5'd7, 5'd6, 3'b011, 5'd5), 32'h6004, 1'b1, 1'b1, 1'b0);
        tick();
`ifdef RV_MEXT_EN
        chk("mulhu_decode", {m_if.ex_valid, m_if.ex_alu_ctrl}, {1'b1, 4'hF});
`else
        exp_ill++;
        chk("mulhu_illegal", m_if.ex_valid, 0);
`endif
        drive(enc_r(7'b0000001, 5'd7, 5'd6, 3'b100, 5'd5), 32'h6008, 1'b1, 1'b1, 1'b0);
        tick();
        exp_ill++;
        chk("div_illegal", m_if.ex_valid, 0);
        chk("div_ill", m_if.ill_count, exp_ill);

        // reset mid-stream together with flush
        drive(32'h00500093, 32'h7000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("mid_pre_valid", m_if.ex_valid, 1);
        reset = 1'b1;
        drive(32'h00500093, 32'h7004, 1'b1, 1'b1, 1'b1);
        tick();
        exp_ill = 0;
        chk("mid_rst_valid", m_if.ex_valid, 0);
        chk("mid_rst_regs", {get_ctrl(), m_if.ex_imm, m_if.ex_pc, m_if.ex_rd}, 0);
        chk("mid_rst_ill", m_if.ill_count, exp_ill);
        reset = 1'b0;
        drive(32'h00000013, 32'h0, 1'b0, 1'b1, 1'b0);

        // 2-bit illegal counter saturates at 3
        s_if.if_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("sat%0d_ill", k), s_if.ill_count, sat_exp[k]);
            chk($sformatf("sat%0d_valid", k), s_if.ex_valid, 0);
        end
        s_if.if_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
